// File: rtl/kugelblitz_patch_sched_if.sv
// AXI-stream bundle for the kugelblitz patch path.
// The master side drives the payload and the slave side drives tready.
interface kugelblitz_patch_sched_if #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/kugelblitz_patch_sched.sv
// Frame-synchronous byte-patch scheduler/applier for a 512-bit stream lane.
// Statistics counters exist only when KG_PATCH_STATS_EN is defined; otherwise the stat outputs are tied to 0.
module kugelblitz_patch_sched #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int NUM_RULES    = 4,
  parameter int OFFSET_WIDTH = 11,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              cfg_valid,
  output logic                                              cfg_ready,
  input  logic [((NUM_RULES > 1) ? $clog2(NUM_RULES) : 1)-1:0] cfg_index,
  input  logic [OFFSET_WIDTH-1:0]                           cfg_offset,
  input  logic [7:0]                                        cfg_data,
  input  logic                                              cfg_enable,
  input  logic                                              commit,
  output logic                                              commit_pending,
  kugelblitz_patch_sched_if.slave                           s_axis,
  kugelblitz_patch_sched_if.master                          m_axis,
  output logic [CNT_WIDTH-1:0]                              stat_frames,
  output logic [CNT_WIDTH-1:0]                              stat_patched
);
  localparam int IDX_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int BEAT_W = OFFSET_WIDTH - 6;
  localparam int HIT_W  = $clog2(KEEP_WIDTH + 1);
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_IN_FRAME = 1'b1;
  // One extra counter bit: the saturated value lies beyond any rule's beat field, so late beats never match.
  localparam logic [BEAT_W:0] BEAT_SAT = {1'b1, {BEAT_W{1'b0}}};

  typedef struct packed {
    logic                    en;
    logic [OFFSET_WIDTH-1:0] off;
    logic [7:0]              data;
  } rule_t;

  rule_t                 sh_q [NUM_RULES];
  rule_t                 sh_d [NUM_RULES];
  rule_t                 act_q[NUM_RULES];
  rule_t                 act_d[NUM_RULES];
  logic [0:0]            state_q, state_d;
  logic [BEAT_W:0]       beat_q, beat_d;
  logic                  pend_q, pend_d;
  logic                  m_vld_q, m_vld_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;
  logic [USER_WIDTH-1:0] m_user_q, m_user_d;

  logic                       s_acc, swap;
  logic [KEEP_WIDTH-1:0]      hit;
  logic [KEEP_WIDTH-1:0][7:0] sel_data;
  logic [DATA_WIDTH-1:0]      pat_data;

  assign s_axis.tready  = !m_vld_q || m_axis.tready;
  assign s_acc          = s_axis.tvalid && s_axis.tready;
  assign cfg_ready      = !pend_q;
  assign commit_pending = pend_q;
  // A beat accepted while idle starts a frame on the old table, so it blocks the swap.
  assign swap           = (state_q == S_IDLE) && pend_q && !s_acc;

  always_comb begin
    sh_d    = sh_q;
    act_d   = act_q;
    pend_d  = pend_q;
    state_d = state_q;
    beat_d  = beat_q;
    if (cfg_valid && cfg_ready)
      for (int r = 0; r < NUM_RULES; r++)
        if (cfg_index == IDX_W'(r))
          sh_d[r] = '{en: cfg_enable, off: cfg_offset, data: cfg_data};
    if (swap) begin
      act_d  = sh_q;
      pend_d = 1'b0;
    end else if (commit) begin
      pend_d = 1'b1;
    end
    if (s_acc) begin
      if (s_axis.tlast) begin
        state_d = S_IDLE;
        beat_d  = '0;
      end else begin
        state_d = S_IN_FRAME;
        if (beat_q != BEAT_SAT) beat_d = beat_q + (BEAT_W+1)'(1);
      end
    end
  end

  // Descending scan so the lowest-index matching rule is the last writer.
  always_comb begin
    hit      = '0;
    sel_data = '0;
    pat_data = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      for (int r = NUM_RULES - 1; r >= 0; r--)
        if (act_q[r].en && ({1'b0, act_q[r].off[OFFSET_WIDTH-1:6]} == beat_q) &&
            (act_q[r].off[5:0] == 6'(k)) && s_axis.tkeep[k]) begin
          hit[k]      = 1'b1;
          sel_data[k] = act_q[r].data;
        end
      pat_data[k*8 +: 8] = hit[k] ? sel_data[k] :
                           (s_axis.tkeep[k] ? s_axis.tdata[k*8 +: 8] : 8'h00);
    end
  end

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_keep_d = m_keep_q;
    m_last_d = m_last_q;
    m_user_d = m_user_q;
    if (s_axis.tready) m_vld_d = s_axis.tvalid;
    if (s_acc) begin
      m_data_d = pat_data;
      m_keep_d = s_axis.tkeep;
      m_last_d = s_axis.tlast;
      m_user_d = s_axis.tuser;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        sh_q[r]  <= '0;
        act_q[r] <= '0;
      end
      state_q  <= S_IDLE;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
      m_user_q <= '0;
    end else begin
      sh_q     <= sh_d;
      act_q    <= act_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      pend_q   <= pend_d;
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_keep_q <= m_keep_d;
      m_last_q <= m_last_d;
      m_user_q <= m_user_d;
    end
  end

  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tuser  = m_user_q;

`ifdef KG_PATCH_STATS_EN
  logic [HIT_W-1:0]     hits, m_hits_q, m_hits_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d, patched_q, patched_d;
  logic                 m_acc;

  assign m_acc = m_vld_q && m_axis.tready;

  // The hit count rides alongside the output beat and is credited when that beat leaves.
  always_comb begin
    hits = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) hits = hits + HIT_W'(hit[k]);
    m_hits_d  = s_acc ? hits : m_hits_q;
    frames_d  = frames_q + CNT_WIDTH'(m_acc && m_last_q);
    patched_d = patched_q + (m_acc ? CNT_WIDTH'(m_hits_q) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hits_q  <= '0;
      frames_q  <= '0;
      patched_q <= '0;
    end else begin
      m_hits_q  <= m_hits_d;
      frames_q  <= frames_d;
      patched_q <= patched_d;
    end
  end

  assign stat_frames  = frames_q;
  assign stat_patched = patched_q;
`else
  assign stat_frames  = '0;
  assign stat_patched = '0;
`endif
endmodule

// File: tb/tb_kugelblitz_patch_sched.sv
// Self-checking bench for kugelblitz_patch_sched: constant vector table, scripted corner sequences,
// and random frames checked against a frame-level patch model.
module tb_kugelblitz_patch_sched;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int NR = 4;
  localparam logic [KW-1:0] ALL = {KW{1'b1}};
`ifdef KG_PATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rst;
  logic        cfg_valid, cfg_ready, cfg_enable, commit, commit_pending;
  logic [1:0]  cfg_index;
  logic [10:0] cfg_offset;
  logic [7:0]  cfg_data;
  logic [31:0] stat_frames, stat_patched;

  kugelblitz_patch_sched_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) s_if ();
  kugelblitz_patch_sched_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) m_if ();

  kugelblitz_patch_sched dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index),
    .cfg_offset(cfg_offset), .cfg_data(cfg_data), .cfg_enable(cfg_enable),
    .commit(commit), .commit_pending(commit_pending),
    .s_axis(s_if), .m_axis(m_if),
    .stat_frames(stat_frames), .stat_patched(stat_patched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit en; int off; int data; } mrule_t;
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    int            hits;
  } beat_t;
  typedef struct {
    logic [KW-1:0] keep;
    logic [7:0]    fill;
    int            lane;
    logic [7:0]    exp_byte;
    int            exp_hits;
  } vec_t;

  mrule_t mdl_sh[NR];
  mrule_t mdl_act[NR];
  bit     mdl_pend;
  beat_t  exp_q[$];
  int     tests, errs, exp_frames, exp_patched, rdy_mode;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: bytes outside tkeep are zero; a kept byte takes the first enabled rule
  // (in ascending index order) whose offset points at this beat and lane.
  function automatic beat_t mdl_beat(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                                     input logic l, input logic u, input int b);
    beat_t x;
    x.data = '0; x.keep = kp; x.last = l; x.user = u; x.hits = 0;
    for (int k = 0; k < KW; k++) begin
      if (kp[k]) begin
        x.data[k*8 +: 8] = d[k*8 +: 8];
        for (int r = 0; r < NR; r++) begin
          if (mdl_act[r].en && (mdl_act[r].off / 64 == b) && (mdl_act[r].off % 64 == k)) begin
            x.data[k*8 +: 8] = 8'(mdl_act[r].data);
            x.hits++;
            break;
          end
        end
      end
    end
    return x;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic mdl_clear();
    for (int r = 0; r < NR; r++) begin
      mdl_sh[r] = '{0, 0, 0};
      mdl_act[r] = '{0, 0, 0};
    end
    mdl_pend = 0;
  endtask

  task automatic mdl_swap();
    mdl_act = mdl_sh;
    mdl_pend = 0;
  endtask

  // Output monitor: every accepted output beat is compared in order against the model queue.
  initial begin : mon
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          tests++; errs++;
          $display("FAIL mon_unexpected: got beat %0h expected none", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("mon_data", m_if.tdata, e.data);
          chk("mon_keep", DW'(m_if.tkeep), DW'(e.keep));
          chk("mon_last_user", DW'({m_if.tlast, m_if.tuser}), DW'({e.last, e.user}));
          exp_patched += e.hits;
          if (e.last) exp_frames++;
        end
      end
    end
  end

  initial begin : rdy_gen
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'b0;
        default: m_if.tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                           input logic l, input logic u, input int b);
    bit ok;
    ok = 0;
    s_if.tdata = d; s_if.tkeep = kp; s_if.tlast = l; s_if.tuser = u; s_if.tvalid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = s_if.tready;
    end
    if (!ok) begin
      tests++; errs++;
      $display("FAIL send_timeout: s_axis_tready got 0 expected 1");
    end else begin
      exp_q.push_back(mdl_beat(d, kp, l, u, b));
    end
    tick();
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit rnd_keep);
    logic [KW-1:0] kp;
    for (int b = 0; b < len; b++) begin
      kp = (rnd_keep && $urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : ALL;
      send_beat(rnd_data(), kp, b == len - 1, 1'($urandom_range(0, 1)), b);
    end
  endtask

  task automatic cfg_write(input int idx, input int off, input int data, input bit en, input bit c);
    bit ok;
    ok = 0;
    cfg_index = 2'(idx); cfg_offset = 11'(off); cfg_data = 8'(data); cfg_enable = en;
    commit = c; cfg_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = cfg_ready;
    end
    if (!ok) begin
      tests++; errs++;
      $display("FAIL cfg_timeout: cfg_ready got 0 expected 1");
    end
    tick();
    cfg_valid = 1'b0; commit = 1'b0;
    mdl_sh[idx] = '{en, off, data};
    if (c) mdl_pend = 1;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    mdl_pend = 1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) tick();
    chk("drain_queue", DW'(exp_q.size()), '0);
    tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_tvalid"}, DW'(m_if.tvalid), '0);
    chk({tag, "_m_tdata"}, m_if.tdata, '0);
    chk({tag, "_m_tkeep"}, DW'(m_if.tkeep), '0);
    chk({tag, "_m_tlast_tuser"}, DW'({m_if.tlast, m_if.tuser}), '0);
    chk({tag, "_commit_pending"}, DW'(commit_pending), '0);
    chk({tag, "_cfg_ready"}, DW'(cfg_ready), DW'(1));
    chk({tag, "_s_tready"}, DW'(s_if.tready), DW'(1));
    chk({tag, "_stat_frames"}, DW'(stat_frames), '0);
    chk({tag, "_stat_patched"}, DW'(stat_patched), '0);
  endtask

  initial begin : main
    vec_t          vt[8];
    logic [DW-1:0] d, e, hold;
    int            p0, f0;

    vt[0] = '{ALL,               8'h00, 5,  8'h11, 2};
    vt[1] = '{ALL,               8'hC3, 12, 8'hAA, 2};
    vt[2] = '{~(64'd1 << 5),     8'hC3, 5,  8'h00, 1};
    vt[3] = '{~(64'd1 << 12),    8'hC3, 12, 8'h00, 1};
    vt[4] = '{ALL,               8'hC3, 20, 8'hC3, 2};
    vt[5] = '{64'h0000_0000_0000_00FF, 8'h5A, 12, 8'h00, 1};
    vt[6] = '{ALL,               8'h5A, 0,  8'h5A, 2};
    vt[7] = '{64'd0,             8'h5A, 5,  8'h00, 0};

    tests = 0; errs = 0; exp_frames = 0; exp_patched = 0; rdy_mode = 0;
    rst = 1'b1; cfg_valid = 1'b0; commit = 1'b0; cfg_index = '0; cfg_offset = '0;
    cfg_data = '0; cfg_enable = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    mdl_clear();
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    @(negedge clk) rst = 1'b0;
    tick();

    // Basic patch, one-cycle latency.
    cfg_write(0, 12, 'hAA, 1, 0);
    do_commit(); tick(); mdl_swap();
    chk("basic_idle_valid", DW'(m_if.tvalid), '0);
    d = rnd_data();
    send_beat(d, ALL, 1, 0, 0);
    chk("basic_latency_valid", DW'(m_if.tvalid), DW'(1));
    e = d; e[12*8 +: 8] = 8'hAA;
    chk("basic_beat", m_if.tdata, e);
    wait_drain();
    chk("basic_stat_patched", DW'(stat_patched), DW'(STATS ? 1 : 0));

    // Vector table: priority, tkeep masking, disabled rule, stat increments.
    cfg_write(0, 5, 'h11, 1, 0);
    cfg_write(1, 12, 'hAA, 1, 0);
    cfg_write(2, 5, 'h22, 1, 0);
    cfg_write(3, 20, 'h77, 0, 0);
    do_commit(); tick(); mdl_swap();
    for (int i = 0; i < 8; i++) begin
      p0 = stat_patched;
      send_beat({KW{vt[i].fill}}, vt[i].keep, 1, 0, 0);
      chk($sformatf("tbl%0d_byte", i), DW'(m_if.tdata[vt[i].lane*8 +: 8]), DW'(vt[i].exp_byte));
      tick();
      chk($sformatf("tbl%0d_hits", i), DW'(stat_patched - p0), DW'(STATS ? vt[i].exp_hits : 0));
    end
    wait_drain();

    // Mid-frame commit: current frame keeps the old (all disabled) table.
    for (int r = 0; r < NR; r++) cfg_write(r, 0, 0, 0, 0);
    do_commit(); tick(); mdl_swap();
    send_beat(rnd_data(), ALL, 0, 0, 0);
    cfg_write(1, 70, 'h55, 1, 0);
    do_commit();
    chk("mid_pending", DW'(commit_pending), DW'(1));
    chk("mid_cfg_ready", DW'(cfg_ready), '0);
    tick();
    chk("mid_pending_hold", DW'(commit_pending), DW'(1));
    send_beat(rnd_data(), ALL, 0, 0, 1);
    send_beat(rnd_data(), ALL, 1, 0, 2);
    chk("mid_pending_at_tlast", DW'(commit_pending), DW'(1));
    chk("mid_cfg_ready_at_tlast", DW'(cfg_ready), '0);
    tick();
    chk("mid_pending_clear", DW'(commit_pending), '0);
    chk("mid_cfg_ready_back", DW'(cfg_ready), DW'(1));
    mdl_swap();
    send_beat(rnd_data(), ALL, 0, 0, 0);
    send_beat(rnd_data(), ALL, 0, 0, 1);
    chk("mid_next_b1_byte6", DW'(m_if.tdata[6*8 +: 8]), DW'(8'h55));
    send_beat(rnd_data(), ALL, 1, 0, 2);
    wait_drain();

    // Backpressure: five stalled cycles mid-frame.
    fork
      send_frame(6, 0);
      begin
        repeat (2) @(negedge clk);
        rdy_mode = 1;
        @(posedge clk); #2;
        hold = m_if.tdata;
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid_held", DW'(m_if.tvalid), DW'(1));
          chk("bp_data_held", m_if.tdata, hold);
          chk("bp_s_tready", DW'(s_if.tready), '0);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();

    // Cfg write and commit in the same cycle: the write is part of the swap.
    cfg_write(2, 200, 'h3C, 1, 1);
    tick(); mdl_swap();
    chk("coll_pending_clear", DW'(commit_pending), '0);
    send_frame(4, 0);
    // First beat accepted in the would-be swap cycle: that frame uses the old table.
    cfg_write(2, 9, 'hC3, 1, 0);
    do_commit();
    send_beat(rnd_data(), ALL, 1, 0, 0);
    chk("coll_first_beat_pending", DW'(commit_pending), DW'(1));
    tick(); mdl_swap();
    chk("coll_swap_after_frame", DW'(commit_pending), '0);
    // Second commit while pending is ignored.
    send_beat(rnd_data(), ALL, 0, 0, 0);
    do_commit();
    do_commit();
    chk("second_commit_pending", DW'(commit_pending), DW'(1));
    send_beat(rnd_data(), ALL, 1, 0, 1);
    tick(); mdl_swap();
    tick(); tick();
    chk("second_commit_ignored", DW'(commit_pending), '0);
    send_frame(2, 0);
    wait_drain();

    // Beat counter saturation: a 34-beat frame must not wrap back onto beat 0.
    cfg_write(0, 3, 'h99, 1, 0);
    cfg_write(1, 31*64 + 1, 'h66, 1, 0);
    do_commit(); tick(); mdl_swap();
    send_frame(34, 0);
    wait_drain();

    // Random frames with random tready and periodic rule reloads.
    rdy_mode = 2;
    for (int f = 0; f < 100; f++) begin
      if (f % 10 == 0) begin
        repeat (2) cfg_write($urandom_range(0, NR-1), $urandom_range(0, 255),
                             $urandom_range(0, 255), 1'($urandom_range(0, 3) != 0), 0);
        do_commit(); tick(); mdl_swap();
      end
      send_frame($urandom_range(1, 4), 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rdy_mode = 0;
    wait_drain();

    // Asynchronous reset mid-frame clears outputs and both tables.
    rdy_mode = 1;
    tick(); tick();
    cfg_write(3, 7, 'hEE, 1, 0);
    send_beat(rnd_data(), ALL, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    mdl_clear();
    exp_frames = 0; exp_patched = 0;
    check_reset("midrst");
    @(negedge clk) rst = 1'b0;
    rdy_mode = 0;
    tick(); tick();
    send_frame(1, 0);
    do_commit(); tick(); mdl_swap();
    send_frame(2, 0);
    wait_drain();

    // Stats over ten frames.
    cfg_write(0, 70, 'h42, 1, 0);
    do_commit(); tick(); mdl_swap();
    f0 = stat_frames;
    for (int f = 0; f < 10; f++) send_frame($urandom_range(1, 3), 1);
    wait_drain();
    chk("stat_frames_10", DW'(stat_frames - f0), DW'(STATS ? 10 : 0));
    chk("stat_frames_total", DW'(stat_frames), DW'(STATS ? exp_frames : 0));
    chk("stat_patched_total", DW'(stat_patched), DW'(STATS ? exp_patched : 0));

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
